// File: rtl/burst_ram_loader_pkg.sv
// burst_ram_loader_pkg
//   Shared definitions for the burst RAM loader: parameter defaults, the
//   external RAM read latency, the FSM state encoding and a helper that
//   sizes the lane index.
//   Optional feature macro used elsewhere: BURST_RAM_LOADER_CHECKSUM_EN.
package burst_ram_loader_pkg;

    localparam int DEF_EXT_AW   = 19;
    localparam int DEF_EXT_DW   = 8;
    localparam int DEF_INT_AW   = 10;
    localparam int DEF_LANES    = 8;

    // Cycles between driving an external address and its data appearing.
    localparam int READ_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME   = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        REISSUE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Width of a lane index; at least one bit.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/burst_ram_loader_if.sv
// burst_ram_loader_if
//   Bundles the loader's control handshake, external RAM read port and
//   internal RAM write port.
//   slave  : the loader (takes control + read data, drives RAM strobes)
//   master : the environment (issues requests, returns read data)
//   With BURST_RAM_LOADER_CHECKSUM_EN defined, adds checksum[15:0].
interface burst_ram_loader_if
    import burst_ram_loader_pkg::*;
#(
    parameter int EXT_AW = DEF_EXT_AW,
    parameter int EXT_DW = DEF_EXT_DW,
    parameter int INT_AW = DEF_INT_AW,
    parameter int LANES  = DEF_LANES
);
    localparam int INT_DW = LANES * EXT_DW;

    // control
    logic              start;
    logic              abort;
    logic [EXT_AW-1:0] startAddr;
    logic [INT_AW-1:0] intBase;
    logic [INT_AW:0]   wordCount;
    logic              byteOrder;
    logic              busy;
    logic              done;
    // external RAM (read only)
    logic [EXT_DW-1:0] externalRamReadData;
    logic [EXT_AW-1:0] externalRamAddress;
    logic              externalRamCEB;
    logic              externalRamOEB;
    logic              externalRamWEB;
    // internal RAM (write only)
    logic [INT_AW-1:0] internalRamAddress;
    logic [INT_DW-1:0] internalRamWdata;
    logic              internalRamCEB;
    logic              internalRamWEB;
`ifdef BURST_RAM_LOADER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    modport slave (
        input  start, abort, startAddr, intBase, wordCount, byteOrder,
               externalRamReadData,
        output externalRamAddress, externalRamCEB, externalRamOEB,
               externalRamWEB, internalRamAddress, internalRamWdata,
               internalRamCEB, internalRamWEB, busy, done
`ifdef BURST_RAM_LOADER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output start, abort, startAddr, intBase, wordCount, byteOrder,
               externalRamReadData,
        input  externalRamAddress, externalRamCEB, externalRamOEB,
               externalRamWEB, internalRamAddress, internalRamWdata,
               internalRamCEB, internalRamWEB, busy, done
`ifdef BURST_RAM_LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface

// File: rtl/lane_assembler.sv
// lane_assembler
//   Packs narrow external-RAM lanes into one internal-RAM word register.
//   clk, resetB  : clock, async active-low reset (word cleared to 0)
//   i_capture    : store i_data into the slot selected by i_lane
//   i_lane       : lane index within the word (0 = first lane read)
//   i_byteOrder  : 0 = lane 0 lands in the MSB slot, 1 = in the LSB slot
//   i_data       : lane data from the external RAM
//   o_word       : assembled word (registered)
module lane_assembler
    import burst_ram_loader_pkg::*;
#(
    parameter int EXT_DW = DEF_EXT_DW,
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = lane_idx_w(LANES)
)(
    input  logic                      clk,
    input  logic                      resetB,
    input  logic                      i_capture,
    input  logic [LANE_W-1:0]         i_lane,
    input  logic                      i_byteOrder,
    input  logic [EXT_DW-1:0]         i_data,
    output logic [LANES*EXT_DW-1:0]   o_word
);
    logic [LANES*EXT_DW-1:0] r_word;
    logic [LANE_W-1:0]       w_slot;

    // Slot counted from the LSB; MSB-first order mirrors the lane index.
    always_comb begin
        w_slot = i_byteOrder ? i_lane : (LANE_W'(LANES - 1) - i_lane);
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_word <= '0;
        end else if (i_capture) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (w_slot == LANE_W'(l)) begin
                    r_word[l*EXT_DW +: EXT_DW] <= i_data;
                end
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/burst_ram_loader.sv
// burst_ram_loader
//   Copies wordCount words from a narrow external RAM (one lane per read)
//   into a wide internal RAM, LANES lanes per internal word.
//   clk     : clock
//   resetB  : asynchronous active-low reset
//   bus     : burst_ram_loader_if.slave -- start/abort/startAddr/intBase/
//             wordCount/byteOrder in, busy/done out, external RAM read port,
//             internal RAM write port (all outputs registered).
//   Optional: BURST_RAM_LOADER_CHECKSUM_EN adds bus.checksum, the 16-bit
//   sum of every lane captured since the last accepted start.
//   Per word: PRIME/REISSUE (1) + READ (LANES) + WRITE (1) cycles.
module burst_ram_loader
    import burst_ram_loader_pkg::*;
#(
    parameter int EXT_AW = DEF_EXT_AW,
    parameter int EXT_DW = DEF_EXT_DW,
    parameter int INT_AW = DEF_INT_AW,
    parameter int LANES  = DEF_LANES
)(
    input  logic               clk,
    input  logic               resetB,
    burst_ram_loader_if.slave  bus
);
    localparam int INT_DW = LANES * EXT_DW;
    localparam int LANE_W = lane_idx_w(LANES);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    // Last lane slot during which an address is still needed: the final
    // lane's data was addressed READ_LATENCY cycles earlier.
    localparam logic [LANE_W-1:0] LANE_LAST_ISSUE = LANE_W'(LANES - 1 - READ_LATENCY);
    localparam logic [INT_AW:0]   ONE_WORD = (INT_AW+1)'(1);

    state_t              r_state;
    state_t              w_stateNext;
    logic [LANE_W-1:0]   r_lane;
    logic [LANE_W-1:0]   w_laneNext;
    logic [INT_AW:0]     r_wordsLeft;
    logic [INT_AW-1:0]   r_intAddr;
    logic [EXT_AW-1:0]   r_extAddr;
    logic                r_order;
    logic                r_extCeB;
    logic                r_intCeB;
    logic                r_busy;
    logic                r_done;
    logic                w_accept;
    logic                w_capture;
    logic                w_advanceWord;
    logic                w_extReadNext;
    logic                w_intWriteNext;
    logic                w_doneNext;
    logic [INT_DW-1:0]   w_word;

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_laneNext    = r_lane;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_advanceWord = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_stateNext = (bus.wordCount == '0) ? DONE : PRIME;
                end
            end
            PRIME, REISSUE: begin
                w_stateNext = READ;
                w_laneNext  = '0;
            end
            READ: begin
                w_capture = 1'b1;
                if (r_lane == LANE_LAST) begin
                    w_stateNext = WRITE;
                end else begin
                    w_laneNext = r_lane + LANE_W'(1);
                end
            end
            WRITE: begin
                if (r_wordsLeft == ONE_WORD) begin
                    w_stateNext = DONE;
                end else begin
                    w_stateNext   = REISSUE;
                    w_advanceWord = 1'b1;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // Abort wins over everything outside IDLE: drop the partial word
        // and any write or done that would follow this edge.
        if (bus.abort && (r_state != IDLE)) begin
            w_stateNext   = IDLE;
            w_capture     = 1'b0;
            w_advanceWord = 1'b0;
        end

        // Strobes are registered, so they are derived from the next state.
        w_extReadNext  = (w_stateNext == PRIME) || (w_stateNext == REISSUE) ||
                         ((w_stateNext == READ) && (w_laneNext <= LANE_LAST_ISSUE));
        w_intWriteNext = (w_stateNext == WRITE);
        w_doneNext     = (r_state == DONE) && !bus.abort;
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_lane      <= '0;
            r_wordsLeft <= '0;
            r_intAddr   <= '0;
            r_extAddr   <= '0;
            r_order     <= 1'b0;
            r_extCeB    <= 1'b1;
            r_intCeB    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_lane <= w_laneNext;
            if (w_accept) begin
                r_extAddr   <= bus.startAddr;
                r_intAddr   <= bus.intBase;
                r_wordsLeft <= bus.wordCount;
                r_order     <= bus.byteOrder;
            end else begin
                // Step past each address once it has actually been issued.
                if (!r_extCeB) begin
                    r_extAddr <= r_extAddr + EXT_AW'(1);
                end
                if (w_advanceWord) begin
                    r_intAddr   <= r_intAddr + INT_AW'(1);
                    r_wordsLeft <= r_wordsLeft - ONE_WORD;
                end
            end
            r_extCeB <= !w_extReadNext;
            r_intCeB <= !w_intWriteNext;
            r_busy   <= (w_stateNext != IDLE);
            r_done   <= w_doneNext;
        end
    end

    lane_assembler #(
        .EXT_DW (EXT_DW),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_assembler (
        .clk         (clk),
        .resetB      (resetB),
        .i_capture   (w_capture),
        .i_lane      (r_lane),
        .i_byteOrder (r_order),
        .i_data      (bus.externalRamReadData),
        .o_word      (w_word)
    );

`ifdef BURST_RAM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_capture) begin
            r_checksum <= r_checksum + 16'(bus.externalRamReadData);
        end
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.externalRamAddress = r_extAddr;
    assign bus.externalRamCEB     = r_extCeB;
    assign bus.externalRamOEB     = r_extCeB;
    assign bus.externalRamWEB     = 1'b1;
    assign bus.internalRamAddress = r_intAddr;
    assign bus.internalRamWdata   = w_word;
    assign bus.internalRamCEB     = r_intCeB;
    assign bus.internalRamWEB     = r_intCeB;
    assign bus.busy               = r_busy;
    assign bus.done               = r_done;

endmodule
